grant_session_mux: RTL and testbench
====================================

# grant_session_mux

Downstream consumer of the 4-way round-robin arbiter's one-hot `grant`. Latches the granted master and routes that master's beat-level valid/ready transfers onto a single shared slave port. Detects the end of the master's session and returns the `session_is_finished` pulse the arbiter uses to re-sample requests and advance its rotate pointer.

## Interface
- `ADDR_W`, 32, address width per beat.
- `DATA_W`, 32, write/read data width.
- `MAX_BURST`, 16, maximum number of beats in one session (≥2).
- `TIMEOUT_CYCLES`, 255, idle cycles allowed in ACTIVE before abort (used only with the watchdog).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `grant` in 4: one-hot grant from the arbiter; registered at the arbiter.
- `session_is_finished` out 1: one-cycle pulse to the arbiter.
- `session_err` out 1: pulses together with `session_is_finished` when a session is aborted.
- `busy` out 1: high in every state except IDLE.
- `owner` out 2: index of the latched master; valid while `busy`.
- `m_valid`, `m_last`, `m_we` in 4 each: per-master beat valid, last beat, write enable.
- `m_addr` in 4×`ADDR_W`, `m_wdata` in 4×`DATA_W`: per-master beat payload.
- `m_ready` out 4: per-master beat accept.
- `m_rvalid` out 4: per-master read-data strobe.
- `m_rdata` out `DATA_W`: read data, shared by all masters.
- `s_valid`, `s_we` out 1 each; `s_addr` out `ADDR_W`; `s_wdata` out `DATA_W`: shared slave request.
- `s_ready` in 1; `s_rdata` in `DATA_W`: slave accept. Read data is valid in the same cycle as the accept.

## Operation
- FSM states: IDLE, ACTIVE, FINISH, HOLDOFF.
- **IDLE**
  - If `grant`≠0, latch `owner` as the index of the lowest set bit and go to ACTIVE.
  - A grant that is not one-hot is resolved by the same lowest-bit rule.
- **ACTIVE: routing**
  - `s_valid` = `m_valid[owner]`. `s_we`, `s_addr` and `s_wdata` come from `owner`.
  - `m_ready[owner]` = `s_ready`.
  - On a read accept (`s_valid & s_ready & !s_we`), `m_rvalid[owner]`=1.
  - All non-owner `m_ready` and `m_rvalid` bits are 0.
- **ACTIVE: beat counting**
  - A beat is accepted on `s_valid & s_ready`. The 4-bit-or-wider beat counter increments on each accept.
  - Accept with `m_last[owner]` → FINISH, `err`=0.
  - The MAX_BURST-th accept without `m_last` → FINISH, `err`=1.
- **FINISH**: lasts 1 cycle.
  - `session_is_finished`=1; `session_err`=`err`.
  - All `s_valid`, `m_ready` and `m_rvalid` are 0.
  - Then go to HOLDOFF.
- **HOLDOFF**: lasts 1 cycle; `grant` is ignored, then go to IDLE.
  - Reason: the arbiter's grant register still holds the previous owner for one edge after it samples the finish pulse.
- `grant` changes during ACTIVE, FINISH or HOLDOFF are ignored.
- `m_rdata` = `s_rdata` at all times (combinational).
- **Reset mid-session**: next state is IDLE, and all registered outputs go to 0 at the reset edge. Any in-flight beat is dropped without a finish pulse.

## Timing
- **Reset values**: `session_is_finished`=0, `session_err`=0, `busy`=0, `owner`=0, `s_valid`=0, `m_ready`=0, `m_rvalid`=0. The beat counter and watchdog are 0.
- **Grant to first beat**: `grant` seen in cycle N → ACTIVE in N+1. The earliest slave handshake is in cycle N+1.
- **Last beat to finish**: last beat accepted in cycle M → `session_is_finished` in M+1, HOLDOFF in M+2, IDLE in M+3. A new grant can be latched at the end of M+3.
- **Session period**: minimum grant-to-grant period is 4 cycles for a 1-beat session.
- **Routing path**: request, ready and rvalid pass through combinationally within ACTIVE, with no added latency per beat.

## Configuration
- Macro: `GRANT_SESSION_WATCHDOG_EN`.
- **Defined**:
  - The watchdog counts consecutive ACTIVE cycles with no accepted beat. It clears on every accept and on leaving ACTIVE.
  - When the count reaches `TIMEOUT_CYCLES`, the block goes to FINISH with `err`=1.
- **Not defined**: no watchdog. ACTIVE waits indefinitely for `m_valid` and `s_ready`, and `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `grant_session_pkg` holds:
  - `NUM_MASTERS`=4.
  - `OWNER_W`=2.
  - The state enum `session_state_t` {IDLE, ACTIVE, FINISH, HOLDOFF}.
- Sub-module `session_watchdog` holds the timeout counter. It has inputs `clk`, `rst`, `enable`, `kick` and output `expired`, and is instantiated only under `GRANT_SESSION_WATCHDOG_EN`.

## Test plan
- **Single write**: `grant`=4'b0100; master 2 presents one beat with `m_last`=1, `m_we`=1, addr 0x10, data 0xA5; `s_ready`=1 → `s_addr`=0x10 and `s_wdata`=0xA5 one cycle after the grant; `session_is_finished` one cycle later; `busy`=0 three cycles after the beat.
- **Read burst**: master 1, 3 beats, `s_ready` low for 2 cycles mid-burst, `s_rdata` 0x1,0x2,0x3 → `m_rvalid[1]` high exactly 3 times; `m_ready[0,2,3]` stay 0; a single finish pulse.
- **Overlong burst**: master 0 sends 16 beats with no `m_last` → finish together with `session_err`=1 on the cycle after the 16th accept.
- **Stale grant after finish**: `grant` held at 4'b0001 for one cycle after the finish pulse, then 4'b1000 → master 0 is not re-latched; `owner`=3 in the next session.
- **Watchdog (macro on)**: `TIMEOUT_CYCLES`=8; granted master never raises `m_valid` → `session_is_finished` and `session_err` after 8 ACTIVE cycles. With the macro off, `busy` stays 1 for 100 cycles.
- **Reset mid-burst**: `rst` asserted during the 2nd beat → all outputs 0 on the next edge; no finish pulse; IDLE after release.

Source files
------------

// File: rtl/grant_session_pkg.sv
// Shared types and constants for the grant session mux.
// Optional watchdog is enabled by defining GRANT_SESSION_WATCHDOG_EN.
package grant_session_pkg;

  localparam int unsigned NUM_MASTERS = 4;
  localparam int unsigned OWNER_W     = 2;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StFinish,
    StHoldoff
  } session_state_t;

  // Non-one-hot grants resolve to the lowest set bit.
  function automatic logic [OWNER_W-1:0] lowest_set(input logic [NUM_MASTERS-1:0] vec);
    logic [OWNER_W-1:0] idx;
    idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (vec[i]) idx = OWNER_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/session_watchdog.sv
// Idle-cycle counter for an active session; only built with GRANT_SESSION_WATCHDOG_EN.
module session_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Fires in the cycle the idle count would reach TIMEOUT_CYCLES.
  assign expired = enable && !kick && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || kick) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/grant_session_mux.sv
// Latches the arbiter's grant, routes the owner's beats to the shared slave port and
// signals session end. Watchdog abort is enabled by GRANT_SESSION_WATCHDOG_EN.
module grant_session_mux
  import grant_session_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        grant,
  output logic                          session_is_finished,
  output logic                          session_err,
  output logic                          busy,
  output logic [OWNER_W-1:0]            owner,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  input  logic [NUM_MASTERS-1:0]        m_last,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_valid,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_ready,
  input  logic [DATA_W-1:0]             s_rdata
);

  localparam int unsigned BeatW =
      ($clog2(MAX_BURST + 1) > 4) ? $clog2(MAX_BURST + 1) : 4;

  session_state_t   state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             err_q, err_d;
  logic             accept;
  logic             wd_expired;

`ifdef GRANT_SESSION_WATCHDOG_EN
  session_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .enable (state_q == StActive),
    .kick   (accept),
    .expired(wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
`endif

  assign m_rdata             = s_rdata;
  assign busy                = (state_q != StIdle);
  assign owner               = owner_q;
  assign session_is_finished = (state_q == StFinish);
  assign session_err         = (state_q == StFinish) && err_q;

  // Owner routing: combinational pass-through while ACTIVE, everything quiet otherwise.
  always_comb begin
    s_valid  = (state_q == StActive) && m_valid[owner_q];
    s_we     = m_we[owner_q];
    s_addr   = m_addr[int'(owner_q)*ADDR_W +: ADDR_W];
    s_wdata  = m_wdata[int'(owner_q)*DATA_W +: DATA_W];
    accept   = s_valid && s_ready;
    m_ready  = '0;
    m_rvalid = '0;
    if (state_q == StActive) begin
      m_ready[owner_q]  = s_ready;
      m_rvalid[owner_q] = accept && !s_we;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = '0;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (|grant) begin
          owner_d = lowest_set(grant);
          err_d   = 1'b0;
          state_d = StActive;
        end
      end
      StActive: begin
        beat_d = beat_q;
        if (accept) begin
          beat_d = beat_q + BeatW'(1);
          if (m_last[owner_q]) begin
            err_d   = 1'b0;
            state_d = StFinish;
          end else if (beat_q == BeatW'(MAX_BURST - 1)) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end
      end
      StFinish:  state_d = StHoldoff;
      // Arbiter's grant register still shows the old owner here.
      StHoldoff: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_grant_session_mux.sv
// Scoreboard bench for grant_session_mux; the watchdog case follows GRANT_SESSION_WATCHDOG_EN.
module tb_grant_session_mux;

  logic        clk;
  logic        rst;
  logic [3:0]  grant;
  logic        session_is_finished, session_err, busy;
  logic [1:0]  owner;
  logic [3:0]  m_valid, m_last, m_we, m_ready, m_rvalid;
  logic [127:0] m_addr, m_wdata;
  logic [31:0] m_rdata;
  logic        s_valid, s_we, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;

  grant_session_mux #(
    .ADDR_W(32), .DATA_W(32), .MAX_BURST(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .grant(grant),
    .session_is_finished(session_is_finished), .session_err(session_err),
    .busy(busy), .owner(owner),
    .m_valid(m_valid), .m_last(m_last), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  mst;
  } beat_t;

  typedef struct {
    logic       err;
    logic [1:0] mst;
  } fin_t;

  beat_t beat_q[$];
  fin_t  fin_q[$];
  int    nchk = 0;
  int    nfail = 0;
  int    rv_cnt = 0;
  logic [3:0] exp_mask = 4'b0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected beats/finishes whenever the DUT presents them.
  beat_t      mb;
  fin_t       mf;
  logic [3:0] oh;
  always @(negedge clk) begin
    if (!rst) begin
      check("m_ready outside owner", {60'd0, m_ready & ~exp_mask}, 64'd0);
      if (s_valid && s_ready) begin
        if (beat_q.size() == 0) begin
          check("unexpected beat", 64'd1, 64'd0);
        end else begin
          mb = beat_q.pop_front();
          oh = 4'b0001 << mb.mst;
          check("s_we", {63'd0, s_we}, {63'd0, mb.we});
          check("s_addr", {32'd0, s_addr}, {32'd0, mb.addr});
          check("m_ready on accept", {60'd0, m_ready}, {60'd0, oh});
          if (mb.we) begin
            check("s_wdata", {32'd0, s_wdata}, {32'd0, mb.wdata});
            check("m_rvalid on write", {60'd0, m_rvalid}, 64'd0);
          end else begin
            check("m_rvalid on read", {60'd0, m_rvalid}, {60'd0, oh});
            check("m_rdata", {32'd0, m_rdata}, {32'd0, mb.rdata});
          end
        end
      end else begin
        check("m_rvalid without accept", {60'd0, m_rvalid}, 64'd0);
      end
      if (m_rvalid != 4'b0000) rv_cnt++;
      if (session_is_finished) begin
        if (fin_q.size() == 0) begin
          check("unexpected finish", 64'd1, 64'd0);
        end else begin
          mf = fin_q.pop_front();
          check("session_err", {63'd0, session_err}, {63'd0, mf.err});
          check("finish owner", {62'd0, owner}, {62'd0, mf.mst});
          check("s_valid in finish", {63'd0, s_valid}, 64'd0);
        end
      end else begin
        check("session_err without finish", {63'd0, session_err}, 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int m, input logic v, input logic we, input logic last,
                            input logic [31:0] addr, input logic [31:0] wdata);
    m_valid[m] = v;
    m_we[m]    = we;
    m_last[m]  = last;
    m_addr[m*32 +: 32]  = addr;
    m_wdata[m*32 +: 32] = wdata;
  endtask

  task automatic beat(input int m, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input logic last);
    beat_t b;
    set_master(m, 1'b1, we, last, addr, wdata);
    s_ready = 1'b1;
    s_rdata = rdata;
    b.we = we; b.addr = addr; b.wdata = wdata; b.rdata = rdata; b.mst = m[1:0];
    beat_q.push_back(b);
    tick();
    m_valid[m] = 1'b0;
    m_last[m]  = 1'b0;
    s_ready    = 1'b0;
  endtask

  task automatic stall(input int m, input int n, input logic [31:0] addr);
    set_master(m, 1'b1, 1'b0, 1'b0, addr, 32'd0);
    s_ready = 1'b0;
    repeat (n) tick();
    m_valid[m] = 1'b0;
  endtask

  task automatic push_fin(input logic err, input logic [1:0] mst);
    fin_t f;
    f.err = err;
    f.mst = mst;
    fin_q.push_back(f);
  endtask

  task automatic start(input logic [3:0] g, input logic [3:0] mask);
    grant    = g;
    exp_mask = mask;
    tick();
  endtask

  // Called in the FINISH cycle; returns at the IDLE-cycle negedge.
  task automatic end_session();
    @(negedge clk);
    check("finish pulse", {63'd0, session_is_finished}, 64'd1);
    tick();
    exp_mask = 4'b0000;
    @(negedge clk);
    check("busy in holdoff", {63'd0, busy}, 64'd1);
    check("no pulse in holdoff", {63'd0, session_is_finished}, 64'd0);
    tick();
    @(negedge clk);
    check("busy back to idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; grant = 4'b0; m_valid = 4'b0; m_last = 4'b0; m_we = 4'b0;
    m_addr = '0; m_wdata = '0; s_ready = 1'b0; s_rdata = 32'd0;
    repeat (3) tick();
    @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset owner", {62'd0, owner}, 64'd0);
    check("reset finish", {63'd0, session_is_finished}, 64'd0);
    check("reset err", {63'd0, session_err}, 64'd0);
    check("reset s_valid", {63'd0, s_valid}, 64'd0);
    check("reset m_ready", {60'd0, m_ready}, 64'd0);
    check("reset m_rvalid", {60'd0, m_rvalid}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single write from master 2.
    start(4'b0100, 4'b0100);
    grant = 4'b0000;
    @(negedge clk);
    check("owner single write", {62'd0, owner}, 64'd2);
    beat(2, 1'b1, 32'h10, 32'hA5, 32'h0, 1'b1);
    push_fin(1'b0, 2'd2);
    end_session();

    // Read burst, master 1, with a 2-cycle stall and a stray grant change.
    rv_cnt = 0;
    start(4'b0010, 4'b0010);
    grant = 4'b0000;
    beat(1, 1'b0, 32'h100, 32'h0, 32'h1, 1'b0);
    grant = 4'b0100;
    stall(1, 2, 32'h104);
    grant = 4'b0000;
    beat(1, 1'b0, 32'h104, 32'h0, 32'h2, 1'b0);
    beat(1, 1'b0, 32'h108, 32'h0, 32'h3, 1'b1);
    push_fin(1'b0, 2'd1);
    end_session();
    check("rvalid count", rv_cnt, 3);

    // Overlong burst from master 0; grant stays 0001 through holdoff.
    start(4'b0001, 4'b0001);
    for (int i = 0; i < 16; i++) begin
      beat(0, 1'b1, 32'h200 + 32'(i * 4), 32'hC0DE0000 + 32'(i), 32'h0, 1'b0);
    end
    push_fin(1'b1, 2'd0);
    end_session();
    start(4'b1000, 4'b1000);
    grant = 4'b0000;
    @(negedge clk);
    check("owner after stale grant", {62'd0, owner}, 64'd3);
    beat(3, 1'b1, 32'h30, 32'h33, 32'h0, 1'b1);
    push_fin(1'b0, 2'd3);
    end_session();

    // Master that never raises m_valid.
    start(4'b0100, 4'b0100);
    grant = 4'b0000;
`ifdef GRANT_SESSION_WATCHDOG_EN
    repeat (7) tick();
    @(negedge clk);
    check("no early timeout", {63'd0, session_is_finished}, 64'd0);
    push_fin(1'b1, 2'd2);
    tick();
    end_session();
`else
    begin
      int idle_bad;
      idle_bad = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (busy !== 1'b1) idle_bad++;
      end
      check("busy held without watchdog", idle_bad, 0);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_mask = 4'b0000;
    tick();
`endif

    // Reset during the second beat of a burst.
    start(4'b0001, 4'b0001);
    grant = 4'b0000;
    beat(0, 1'b1, 32'h40, 32'h44, 32'h0, 1'b0);
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h55);
    s_ready = 1'b1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst owner", {62'd0, owner}, 64'd0);
    check("rst s_valid", {63'd0, s_valid}, 64'd0);
    check("rst m_ready", {60'd0, m_ready}, 64'd0);
    check("rst finish", {63'd0, session_is_finished}, 64'd0);
    tick();
    rst = 1'b0;
    m_valid = 4'b0000;
    s_ready = 1'b0;
    exp_mask = 4'b0000;
    repeat (4) tick();
    @(negedge clk);
    check("idle after reset release", {63'd0, busy}, 64'd0);
    tick();
    start(4'b0100, 4'b0100);
    grant = 4'b0000;
    beat(2, 1'b0, 32'h50, 32'h0, 32'h77, 1'b1);
    push_fin(1'b0, 2'd2);
    end_session();

    tick();
    check("beats left over", beat_q.size(), 0);
    check("finishes left over", fin_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
